// File: rtl/scan_mux_reg.sv
// Registered N-channel multiplexer with manual (strobed) select and a
// round-robin auto-scan mode with programmable per-channel dwell.
module scan_mux_reg #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 50000000
) (
    input  logic                      CLOCK_50,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_load,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      y_valid,
    output logic                      scan_wrap,
    output logic                      sel_err
);

    localparam int                 CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W:0]     NUM_CH   = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0]   LAST_SEL = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL - 1);

    logic [WIDTH-1:0] y_q, y_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_valid_q, y_valid_d;
    logic             scan_wrap_q, scan_wrap_d;
    logic             sel_err_q, sel_err_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        y_d         = din[cur_sel_q*WIDTH +: WIDTH];
        cur_sel_d   = cur_sel_q;
        cnt_d       = cnt_q;
        y_valid_d   = 1'b1;
        scan_wrap_d = 1'b0;
        sel_err_d   = 1'b0;

        if (mode) begin
            // The counter is always 0 on entry to scan (held at 0 in manual),
            // so the channel current at entry gets its full dwell.
            if (!hold) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (cur_sel_q == LAST_SEL) begin
                        cur_sel_d   = '0;
                        scan_wrap_d = 1'b1;
                    end else begin
                        cur_sel_d = cur_sel_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else begin
            cnt_d = '0;
            if (sel_load) begin
                if ({1'b0, sel} < NUM_CH) begin
                    cur_sel_d = sel;
                end else begin
                    sel_err_d = 1'b1;
                end
            end
        end
    end

    // NOTE: reset is synchronous here -- rst_n is only looked at on the rising clock edge.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
        if (!rst_n) begin
            y_q         <= '0;
            cur_sel_q   <= '0;
            cnt_q       <= '0;
            y_valid_q   <= 1'b0;
            scan_wrap_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            y_q         <= y_d;
            cur_sel_q   <= cur_sel_d;
            cnt_q       <= cnt_d;
            y_valid_q   <= y_valid_d;
            scan_wrap_q <= scan_wrap_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign y         = y_q;
    assign cur_sel   = cur_sel_q;
    assign y_valid   = y_valid_q;
    assign scan_wrap = scan_wrap_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_scan_mux_reg.sv
// Directed bench for scan_mux_reg: three instances cover 8-channel manual use,
// a non-power-of-2 channel count, and a 4-channel scan with short dwell.
module tb_scan_mux_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Instance A: WIDTH=1, CHANNELS=8
    logic       rst_n;
    logic [7:0] a_din;
    logic [2:0] a_sel, a_cur_sel;
    logic       a_sel_load, a_mode, a_hold;
    logic [0:0] a_y;
    logic       a_y_valid, a_scan_wrap, a_sel_err;

    scan_mux_reg #(.WIDTH(1), .CHANNELS(8), .SEL_W(3), .DWELL(4)) u_a (
        .CLOCK_50(clk), .rst_n(rst_n), .din(a_din), .sel(a_sel),
        .sel_load(a_sel_load), .mode(a_mode), .hold(a_hold), .y(a_y),
        .cur_sel(a_cur_sel), .y_valid(a_y_valid), .scan_wrap(a_scan_wrap),
        .sel_err(a_sel_err)
    );

    // Instance B: CHANNELS=6, so selects 6 and 7 are out of range
    logic [5:0] b_din;
    logic [2:0] b_sel, b_cur_sel;
    logic       b_sel_load, b_mode, b_hold;
    logic [0:0] b_y;
    logic       b_y_valid, b_scan_wrap, b_sel_err;

    scan_mux_reg #(.WIDTH(1), .CHANNELS(6), .SEL_W(3), .DWELL(2)) u_b (
        .CLOCK_50(clk), .rst_n(rst_n), .din(b_din), .sel(b_sel),
        .sel_load(b_sel_load), .mode(b_mode), .hold(b_hold), .y(b_y),
        .cur_sel(b_cur_sel), .y_valid(b_y_valid), .scan_wrap(b_scan_wrap),
        .sel_err(b_sel_err)
    );

    // Instance C: WIDTH=4, CHANNELS=4, DWELL=3, own reset
    logic        c_rst_n;
    logic [15:0] c_din;
    logic [1:0]  c_sel, c_cur_sel;
    logic        c_sel_load, c_mode, c_hold;
    logic [3:0]  c_y;
    logic        c_y_valid, c_scan_wrap, c_sel_err;

    scan_mux_reg #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(3)) u_c (
        .CLOCK_50(clk), .rst_n(c_rst_n), .din(c_din), .sel(c_sel),
        .sel_load(c_sel_load), .mode(c_mode), .hold(c_hold), .y(c_y),
        .cur_sel(c_cur_sel), .y_valid(c_y_valid), .scan_wrap(c_scan_wrap),
        .sel_err(c_sel_err)
    );

    int exp_cs [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are read away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;  c_rst_n = 1'b0;
        a_din = 8'hA5; a_sel = '0; a_sel_load = 1'b0; a_mode = 1'b0; a_hold = 1'b0;
        b_din = 6'b00_0100; b_sel = '0; b_sel_load = 1'b0; b_mode = 1'b0; b_hold = 1'b0;
        c_din = 16'h3210; c_sel = '0; c_sel_load = 1'b0; c_mode = 1'b0; c_hold = 1'b0;

        // Reset held for three edges
        tick(); tick(); tick();
        check("rst_y",       32'(a_y),       32'd0);
        check("rst_cur_sel", 32'(a_cur_sel), 32'd0);
        check("rst_y_valid", 32'(a_y_valid), 32'd0);
        check("rst_wrap",    32'(a_scan_wrap), 32'd0);
        check("rst_sel_err", 32'(a_sel_err), 32'd0);
        check("rst_c_y",     32'(c_y),       32'd0);

        rst_n = 1'b1; c_rst_n = 1'b1;
        tick();
        check("first_y_valid", 32'(a_y_valid), 32'd1);
        check("first_y",       32'(a_y),       32'd1);

        // Manual select on A
        a_din = 8'b1000_0000; a_sel = 3'd7; a_sel_load = 1'b1;
        tick();
        a_sel_load = 1'b0;
        check("man_cur_sel7", 32'(a_cur_sel), 32'd7);
        check("man_y_lag",    32'(a_y),       32'd0);
        tick();
        check("man_y7", 32'(a_y), 32'd1);
        a_sel = 3'd6; a_sel_load = 1'b1;
        tick();
        a_sel_load = 1'b0;
        check("man_cur_sel6", 32'(a_cur_sel), 32'd6);
        check("man_y6_lag",   32'(a_y),       32'd1);
        tick();
        check("man_y6",      32'(a_y),       32'd0);
        check("man_sel_err", 32'(a_sel_err), 32'd0);

        // Out-of-range load on B (CHANNELS=6)
        b_sel = 3'd2; b_sel_load = 1'b1;
        tick();
        b_sel_load = 1'b0;
        tick();
        check("oor_pre_cur_sel", 32'(b_cur_sel), 32'd2);
        check("oor_pre_y",       32'(b_y),       32'd1);
        b_sel = 3'd6; b_sel_load = 1'b1;
        tick();
        b_sel_load = 1'b0;
        check("oor_sel_err",  32'(b_sel_err), 32'd1);
        check("oor_cur_sel",  32'(b_cur_sel), 32'd2);
        check("oor_y",        32'(b_y),       32'd1);
        tick();
        check("oor_err_clr",  32'(b_sel_err), 32'd0);
        check("oor_cur_sel2", 32'(b_cur_sel), 32'd2);

        // Scan on C starting from channel 0
        c_mode = 1'b1;
        check("scan_cs0", 32'(c_cur_sel), 32'd0);
        for (int k = 1; k < 13; k++) begin
            tick();
            check($sformatf("scan_cs%0d", k), 32'(c_cur_sel), 32'(exp_cs[k]));
            check($sformatf("scan_y%0d", k), 32'(c_y), 32'(exp_cs[k-1]));
            check($sformatf("scan_wrap%0d", k), 32'(c_scan_wrap), (k == 12) ? 32'd1 : 32'd0);
        end
        check("scan_sel_err", 32'(c_sel_err), 32'd0);

        // Hold mid-dwell: channel 0 with counter at 1; strobes are ignored in scan
        tick();
        check("wrap_clr", 32'(c_scan_wrap), 32'd0);
        c_hold = 1'b1; c_sel = 2'd3; c_sel_load = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("hold_cs%0d", k), 32'(c_cur_sel), 32'd0);
            check($sformatf("hold_y%0d", k),  32'(c_y),       32'd0);
        end
        c_hold = 1'b0; c_sel_load = 1'b0;
        tick();
        check("resume_cs0", 32'(c_cur_sel), 32'd0);
        tick();
        check("resume_cs1", 32'(c_cur_sel), 32'd1);
        tick(); tick(); tick();
        check("reach_cs2", 32'(c_cur_sel), 32'd2);

        // Scan -> manual at channel 2: no further advance
        c_mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("manual_cs%0d", k), 32'(c_cur_sel), 32'd2);
        end
        check("manual_y", 32'(c_y), 32'd2);

        // Back to scan from channel 2 with a fresh dwell, reach channel 3 / counter 1
        c_mode = 1'b1;
        tick(); tick();
        check("rescan_cs2", 32'(c_cur_sel), 32'd2);
        tick(); tick();
        check("rescan_cs3", 32'(c_cur_sel), 32'd3);

        // Reset mid-scan
        c_rst_n = 1'b0;
        tick();
        check("mid_rst_y",       32'(c_y),         32'd0);
        check("mid_rst_cs",      32'(c_cur_sel),   32'd0);
        check("mid_rst_y_valid", 32'(c_y_valid),   32'd0);
        check("mid_rst_wrap",    32'(c_scan_wrap), 32'd0);
        c_rst_n = 1'b1;
        tick();
        check("post_rst_cs_a",    32'(c_cur_sel), 32'd0);
        check("post_rst_y_valid", 32'(c_y_valid), 32'd1);
        check("post_rst_y",       32'(c_y),       32'd0);
        tick();
        check("post_rst_cs_b", 32'(c_cur_sel), 32'd0);
        tick();
        check("post_rst_cs_c", 32'(c_cur_sel), 32'd1);
        tick();
        check("post_rst_y1", 32'(c_y), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scan_mux_reg.md
Name: scan_mux_reg

Overview:
- Parametrised, registered N-channel multiplexer; successor to the 8:1 single-bit selector on the board I/O.
- Two modes:
  - Manual: select latched on a strobe.
  - Auto-scan: channels visited round-robin, each held for a programmable dwell time.
- Sits between board switches/data sources and the LED/display output stage.
- Gives glitch-free, clocked output and a scan-wrap indication.

Parameters:
- WIDTH, 1, bits per channel.
- CHANNELS, 8, number of input channels (2..256).
- SEL_W, 3, select width; must equal clog2(CHANNELS).
- DWELL, 50000000, clock cycles per channel in scan mode (>=1).

Ports:
- CLOCK_50 in 1: system clock; all logic on rising edge.
- rst_n in 1: synchronous active-low reset.
- din in CHANNELS*WIDTH: flattened channel data; channel k occupies din[k*WIDTH +: WIDTH].
- sel in SEL_W: requested channel (manual mode).
- sel_load in 1: strobe; capture sel into the active select.
- mode in 1: 0 = manual, 1 = auto-scan.
- hold in 1: freezes scan progression (scan mode only).
- y out WIDTH: registered selected data.
- cur_sel out SEL_W: active channel index.
- y_valid out 1: y holds real selected data.
- scan_wrap out 1: one-cycle pulse when scan moves from CHANNELS-1 to 0.
- sel_err out 1: one-cycle pulse on an out-of-range load.

Behaviour:
- Reset, on a rising edge with rst_n=0: y=0, cur_sel=0, y_valid=0, scan_wrap=0, sel_err=0, dwell counter=0.
  - Reset mid-scan abandons the scan; the next scan restarts at channel 0.
- Datapath: every cycle y <= din[cur_sel]; 1-cycle latency from din to y.
  - y_valid goes to 1 on the first non-reset edge and stays 1 until the next reset.
- Manual mode (mode=0):
  - sel_load=1 with sel<CHANNELS: cur_sel <= sel at that edge.
  - y reflects the new channel one edge later, i.e. 2 edges after the strobe.
  - sel_load=1 with sel>=CHANNELS: cur_sel unchanged and sel_err=1 for 1 cycle. Reachable only when CHANNELS is not a power of 2.
  - sel_load=0: cur_sel held. Dwell counter held at 0. hold ignored.
- Scan mode (mode=1):
  - Dwell counter increments each cycle with hold=0.
  - When the counter equals DWELL-1: counter <= 0, and cur_sel <= cur_sel+1, or 0 if cur_sel=CHANNELS-1.
  - On that wrap, scan_wrap=1 for the following cycle.
  - Each channel is active for exactly DWELL cycles.
  - DWELL=1: cur_sel advances every cycle.
  - hold=1: counter and cur_sel frozen; y keeps tracking din[cur_sel].
  - sel_load and sel ignored; sel_err never asserts.
- Mode transitions:
  - 0->1: counter cleared to 0 on the edge mode is first seen high; scanning starts from the current cur_sel.
  - 1->0: cur_sel retains the channel reached; counter cleared.
  - sel_load is evaluated on the same edge as a 1->0 transition, using manual rules.
- Counter width: clog2(DWELL) bits minimum. No overflow path exists.
- Priority: reset > mode > hold/sel_load.
- No combinational path from any input to any output.

Test Plan:
- Reset with WIDTH=1, CHANNELS=8, din=8'hA5, rst_n held low for 3 edges → y=0, cur_sel=0, y_valid=0; y_valid=1 and y=1 (bit0 of A5) after the first edge with rst_n=1.
- Manual select: mode=0, din=8'b1000_0000, pulse sel_load with sel=7 → cur_sel=7 next edge, y=1 one edge later; then sel=6 load → y=0 after 2 edges.
- Out-of-range load: CHANNELS=6, SEL_W=3, cur_sel=2, sel_load with sel=6 → sel_err pulses 1 cycle, cur_sel stays 2, y unchanged.
- Scan sequence with DWELL=3, CHANNELS=4, WIDTH=4, din={4'h3,4'h2,4'h1,4'h0}, mode=1 from cur_sel=0 → cur_sel sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; y follows one cycle late; scan_wrap pulses once at the 3→0 transition.
- Hold and mode switch: in scan, assert hold for 5 cycles mid-dwell → cur_sel and counter frozen, remaining dwell resumes exactly; then set mode=0 at cur_sel=2 → cur_sel stays 2 with no further advance.
- Reset mid-scan: rst_n low while cur_sel=3 and counter=1 → all outputs reset; after release with mode=1, channel 0 is held for a full DWELL cycles.
